// File: rtl/as_pack.sv
// Shared types and constants for the as_* execute-side helpers.
// Holds the divide sequencer op/state encodings and ALU select codes.
package as_pack;

    localparam int reg_width      = 64;
    localparam int aluselrv_width = 5;

    typedef enum logic [1:0] {
        OP_DIVU = 2'b00,
        OP_REMU = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        DS_IDLE,
        DS_NEGA,
        DS_NEGB,
        DS_CMP,
        DS_SUB,
        DS_FIXQ,
        DS_FIXR,
        DS_DONE
    } divseq_state_t;

    localparam logic [aluselrv_width-1:0] ALUSEL_SUB  = 5'd1;
    localparam logic [aluselrv_width-1:0] ALUSEL_SLTU = 5'd6;

endpackage

// File: rtl/as_divseq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer that borrows the shared ALU.
// Restoring division, one SLTU + one SUB per quotient bit.
module as_divseq
    import as_pack::*;
#(
    parameter int XLEN     = reg_width,
    parameter int ALUSEL_W = aluselrv_width
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [XLEN-1:0]     req_a_i,
    input  logic [XLEN-1:0]     req_b_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [XLEN-1:0]     rsp_data_o,
    output logic                alu_req_o,
    input  logic                alu_gnt_i,
    output logic [ALUSEL_W-1:0] alu_sel_o,
    output logic [XLEN-1:0]     alu_a_o,
    output logic [XLEN-1:0]     alu_b_o,
    input  logic [XLEN-1:0]     alu_result_i
);

    divseq_state_t state, state_nxt;

    logic [1:0]      op;
    logic            a_neg;
    logic            b_neg;
    logic            lt;
    logic [6:0]      cnt;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] d;

    logic [XLEN-1:0] r_sh;
    logic            top;
    logic            b_zero;
    logic            ovf;
    logic            last;

    assign r_sh   = {r[XLEN-2:0], q[XLEN-1]};
    assign top    = r[XLEN-1];
    assign b_zero = (req_b_i == '0);
    assign ovf    = req_op_i[1]
                  & (req_a_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (&req_b_i);
    assign last   = (cnt == 7'(XLEN-1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        alu_req_o   = 1'b0;
        alu_sel_o   = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        unique case (state)
            DS_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (b_zero || ovf)   state_nxt = DS_DONE;
                    else if (req_op_i[1]) state_nxt = DS_NEGA;
                    else                  state_nxt = DS_CMP;
                end
            end
            DS_NEGA: begin
                alu_req_o = 1'b1;
                alu_sel_o = ALUSEL_SUB;
                alu_b_o   = q;
                if (alu_gnt_i) state_nxt = DS_NEGB;
            end
            DS_NEGB: begin
                alu_req_o = 1'b1;
                alu_sel_o = ALUSEL_SUB;
                alu_b_o   = d;
                if (alu_gnt_i) state_nxt = DS_CMP;
            end
            DS_CMP: begin
                alu_req_o = 1'b1;
                alu_sel_o = ALUSEL_SLTU;
                alu_a_o   = r_sh;
                alu_b_o   = d;
                if (alu_gnt_i) state_nxt = DS_SUB;
            end
            DS_SUB: begin
                alu_req_o = 1'b1;
                alu_sel_o = ALUSEL_SUB;
                alu_a_o   = r_sh;
                alu_b_o   = d;
                if (alu_gnt_i) begin
                    if (!last)      state_nxt = DS_CMP;
                    else if (op[1]) state_nxt = DS_FIXQ;
                    else            state_nxt = DS_DONE;
                end
            end
            DS_FIXQ: begin
                alu_req_o = 1'b1;
                alu_sel_o = ALUSEL_SUB;
                alu_b_o   = q;
                if (alu_gnt_i) state_nxt = DS_FIXR;
            end
            DS_FIXR: begin
                alu_req_o = 1'b1;
                alu_sel_o = ALUSEL_SUB;
                alu_b_o   = r;
                if (alu_gnt_i) state_nxt = DS_DONE;
            end
            DS_DONE: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = op[0] ? r : q;
                if (rsp_ready_i) state_nxt = DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    // Datapath only moves on a granted cycle; a stalled state keeps everything.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            op    <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            lt    <= 1'b0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
        end else begin
            unique case (state)
                DS_IDLE: begin
                    if (req_valid_i) begin
                        op    <= req_op_i;
                        a_neg <= req_op_i[1] & req_a_i[XLEN-1];
                        b_neg <= req_op_i[1] & req_b_i[XLEN-1];
                        lt    <= 1'b0;
                        cnt   <= '0;
                        d     <= req_b_i;
                        q     <= b_zero ? '1 : req_a_i;
                        r     <= b_zero ? req_a_i : '0;
                    end
                end
                DS_NEGA: if (alu_gnt_i && a_neg) q <= alu_result_i;
                DS_NEGB: if (alu_gnt_i && b_neg) d <= alu_result_i;
                DS_CMP:  if (alu_gnt_i) lt <= alu_result_i[0] & ~top;
                DS_SUB: begin
                    if (alu_gnt_i) begin
                        r   <= lt ? r_sh : alu_result_i;
                        q   <= {q[XLEN-2:0], ~lt};
                        cnt <= cnt + 7'd1;
                    end
                end
                DS_FIXQ: if (alu_gnt_i && (a_neg ^ b_neg)) q <= alu_result_i;
                DS_FIXR: if (alu_gnt_i && a_neg) r <= alu_result_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_as_divseq.sv
// Randomized bench for as_divseq against a plain-arithmetic divide model.
// A simple ALU model answers the sequencer's SUB/SLTU requests.
module tb_as_divseq;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [63:0] req_a_i;
    logic [63:0] req_b_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic        alu_req_o;
    logic        alu_gnt_i;
    logic [4:0]  alu_sel_o;
    logic [63:0] alu_a_o;
    logic [63:0] alu_b_o;
    logic [63:0] alu_result_i;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk_i = ~clk_i;

    as_divseq dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .alu_req_o    (alu_req_o),
        .alu_gnt_i    (alu_gnt_i),
        .alu_sel_o    (alu_sel_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i)
    );

    always_comb begin
        alu_result_i = '0;
        if (alu_sel_o == 5'd1) alu_result_i = alu_a_o - alu_b_o;
        else if (alu_sel_o == 5'd6) alu_result_i = {63'd0, alu_a_o < alu_b_o};
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [1:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] qv, rv;
        sa = a;
        sb = b;
        if (b == 0) begin
            qv = ONES;
            rv = a;
        end else if (op[1] && a == MIN && b == ONES) begin
            qv = a;
            rv = 0;
        end else if (op[1]) begin
            qv = sa / sb;
            rv = sa % sb;
        end else begin
            qv = a / b;
            rv = a % b;
        end
        return op[0] ? rv : qv;
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 300));
            1: return MIN;
            2: return ONES;
            3: return 64'd0;
            4: return -64'($urandom_range(1, 300));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // gm: 0 grant always, 1 grant every other cycle, 2 random grant + junk requests
    task automatic do_op(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int gm, input int hold);
        logic [63:0] exp;
        int base, lat, stalls;
        exp = ref_div(op, a, b);
        if (b == 0 || (op[1] && a == MIN && b == ONES)) base = 1;
        else if (op[1]) base = 133;
        else base = 129;
        lat = 0;
        stalls = 0;
        @(negedge clk_i);
        chk("idle_ready", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_a_i = a;
        req_b_i = b;
        for (int i = 0; i < 2000; i++) begin
            if (i > 0) begin
                @(negedge clk_i);
                if (gm == 2) begin
                    req_valid_i = 1'($urandom_range(0, 1));
                    req_op_i = 2'($urandom);
                    req_a_i = {$urandom, $urandom};
                    req_b_i = {$urandom, $urandom};
                end
            end
            case (gm)
                0: alu_gnt_i = 1'b1;
                1: alu_gnt_i = (i % 2) == 1;
                default: alu_gnt_i = $urandom_range(0, 3) != 0;
            endcase
            #1;
            if (alu_req_o && !alu_gnt_i) stalls++;
            @(posedge clk_i);
            lat++;
            #1;
            if (lat == 1) req_valid_i = 1'b0;
            if (rsp_valid_o) break;
        end
        req_valid_i = 1'b0;
        alu_gnt_i = 1'b1;
        chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
        chk("rsp_data", rsp_data_o, exp);
        chk("latency", 64'(lat), 64'(base + stalls));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk_i);
            #1;
            chk("hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("hold_data", rsp_data_o, exp);
            chk("hold_ready", 64'(req_ready_o), 64'd0);
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        chk("rsp_clear", 64'(rsp_valid_o), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_data"}, rsp_data_o, 64'd0);
        chk({tag, "_areq"}, 64'(alu_req_o), 64'd0);
        chk({tag, "_asel"}, 64'(alu_sel_o), 64'd0);
        chk({tag, "_aa"}, alu_a_o, 64'd0);
        chk({tag, "_ab"}, alu_b_o, 64'd0);
    endtask

    initial begin
        rstn_i = 1'b0;
        req_valid_i = 1'b0;
        req_op_i = '0;
        req_a_i = '0;
        req_b_i = '0;
        rsp_ready_i = 1'b0;
        alu_gnt_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outs("rst");
        @(negedge clk_i);
        rstn_i = 1'b1;

        do_op(2'b00, 64'd100, 64'd7, 0, 0);
        do_op(2'b01, 64'd100, 64'd7, 0, 0);
        do_op(2'b10, -64'd7, 64'd2, 0, 0);
        do_op(2'b11, -64'd7, 64'd2, 0, 0);
        do_op(2'b10, 64'd7, -64'd2, 0, 0);
        do_op(2'b00, 64'd5, 64'd0, 0, 0);
        do_op(2'b11, 64'd5, 64'd0, 0, 0);
        do_op(2'b10, MIN, ONES, 0, 0);
        do_op(2'b11, MIN, ONES, 0, 0);
        do_op(2'b01, ONES, 64'h8000_0000_0000_0001, 0, 0);
        do_op(2'b00, 64'd100, 64'd7, 1, 0);
        do_op(2'b11, -64'd100, 64'd7, 1, 10);

        // Abort mid-iteration with an async reset.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i = 2'b00;
        req_a_i = 64'd1000;
        req_b_i = 64'd3;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (30) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_op(2'b00, 64'd9, 64'd3, 0, 0);

        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom), rnd_val(), rnd_val(),
                  $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
